// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the multi-bit shift sequencer.
package shift_seq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        CAPTURE = 2'd2
    } seq_state_t;

    localparam logic MODE_ARITH = 1'b0;
    localparam logic MODE_LOGIC = 1'b1;

endpackage

// File: rtl/right_shift_register.sv
// Single-bit right-shift register: one shift per enabled clock edge.
module right_shift_register
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             en,
    input  logic             mode,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic fill;

    assign fill = (mode == MODE_LOGIC) ? 1'b0 : d[WIDTH-1];

    // No reset: contents are always reloaded before being observed.
    always_ff @(posedge clk) begin
        if (en) begin
            q <= {fill, d[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Variable-amount right shifter built by iterating a single-bit
// shift register under a start/ready, done-pulse handshake.
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] operand,
    input  logic [CNT_W-1:0] amount,
    input  logic             mode,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam logic [CNT_W-1:0] MAX_AMT = CNT_W'(WIDTH);

    seq_state_t       state, state_d;
    logic [CNT_W-1:0] rem, rem_d;
    logic             first, first_d;
    logic [WIDTH-1:0] op_q, op_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] result_d;
    logic             done_d;
    logic [CNT_W-1:0] amt_clamp;
    logic             en;
    logic [WIDTH-1:0] reg_d, reg_q;

    assign amt_clamp = (amount > MAX_AMT) ? MAX_AMT : amount;

    // The register is seeded from the captured operand, then recirculates.
    assign reg_d = first ? op_q : reg_q;

    right_shift_register #(
        .WIDTH(WIDTH)
    ) u_dp (
        .clk (clk),
        .en  (en),
        .mode(mode_q),
        .d   (reg_d),
        .q   (reg_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rem    <= '0;
            first  <= 1'b0;
            op_q   <= '0;
            mode_q <= 1'b0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_d;
            rem    <= rem_d;
            first  <= first_d;
            op_q   <= op_d;
            mode_q <= mode_d;
            result <= result_d;
            done   <= done_d;
        end
    end

    always_comb begin
        state_d  = state;
        rem_d    = rem;
        first_d  = first;
        op_d     = op_q;
        mode_d   = mode_q;
        result_d = result;
        done_d   = 1'b0;
        ready    = 1'b0;
        en       = 1'b0;
        unique case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    op_d   = operand;
                    mode_d = mode;
                    rem_d  = amt_clamp;
                    if (amt_clamp == '0) begin
                        result_d = operand;
                        done_d   = 1'b1;
                    end else begin
                        state_d = SHIFT;
                        first_d = 1'b1;
                    end
                end
            end
            SHIFT: begin
                en      = 1'b1;
                first_d = 1'b0;
                rem_d   = rem - CNT_W'(1);
                if (rem == CNT_W'(1)) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                result_d = reg_q;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed vector bench for shift_sequencer (WIDTH=16).
module tb_shift_sequencer;

    localparam int WIDTH = 16;
    localparam int CNT_W = 5;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] operand;
    logic [CNT_W-1:0] amount;
    logic             mode;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] result;

    int errors;
    int checks;

    typedef struct {
        logic [15:0] op;
        logic [4:0]  amt;
        logic        md;
        logic [15:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[11];

    shift_sequencer #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .operand(operand),
        .amount (amount),
        .mode   (mode),
        .ready  (ready),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive a request at a negedge; returns at the negedge after accept.
    task automatic issue(input logic [15:0] op, input logic [4:0] a,
                         input logic md);
        operand = op;
        amount  = a;
        mode    = md;
        start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start   = 1'b0;
        operand = 16'($urandom);
        amount  = 5'($urandom);
        mode    = 1'($urandom);
    endtask

    // Counts edges after accept until done, checking ready stays low.
    task automatic wait_done(input int lat0, output int lat,
                             output bit busy_ok);
        lat     = lat0;
        busy_ok = 1'b1;
        while (!done && lat < 60) begin
            if (ready) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat;
        bit bok;
        bit seen;
        errors  = 0;
        checks  = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        operand = '0;
        amount  = '0;
        mode    = 1'b0;

        vecs[0]  = '{16'hF000, 5'd4,  1'b0, 16'hFF00, 5};
        vecs[1]  = '{16'hF000, 5'd4,  1'b1, 16'h0F00, 5};
        vecs[2]  = '{16'h8001, 5'd1,  1'b1, 16'h4000, 2};
        vecs[3]  = '{16'h1234, 5'd0,  1'b0, 16'h1234, 0};
        vecs[4]  = '{16'h8001, 5'd31, 1'b0, 16'hFFFF, 17};
        vecs[5]  = '{16'h8001, 5'd31, 1'b1, 16'h0000, 17};
        vecs[6]  = '{16'h8001, 5'd15, 1'b1, 16'h0001, 16};
        vecs[7]  = '{16'hA5A5, 5'd3,  1'b0, 16'hF4B4, 4};
        vecs[8]  = '{16'hA5A5, 5'd3,  1'b1, 16'h14B4, 4};
        vecs[9]  = '{16'h7FFF, 5'd16, 1'b0, 16'h0000, 17};
        vecs[10] = '{16'h8000, 5'd1,  1'b0, 16'hC000, 2};

        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            chk($sformatf("v%0d_ready", i), 32'(ready), 32'd1);
            issue(vecs[i].op, vecs[i].amt, vecs[i].md);
            wait_done(0, lat, bok);
            chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("v%0d_result", i), 32'(result), 32'(vecs[i].exp));
            chk($sformatf("v%0d_busy", i), 32'(bok), 32'd1);
            @(negedge clk);
            chk($sformatf("v%0d_pulse", i), 32'(done), 32'd0);
        end

        // Busy start ignored, then back-to-back start in the done cycle.
        issue(16'hF000, 5'd3, 1'b0);
        operand = 16'h1234;
        amount  = 5'd0;
        mode    = 1'b1;
        start   = 1'b1;
        repeat (2) @(negedge clk);
        start   = 1'b0;
        wait_done(2, lat, bok);
        chk("b2b_first_lat", 32'(lat), 32'd4);
        chk("b2b_first_result", 32'(result), 32'hFE00);
        chk("b2b_done_ready", 32'(ready), 32'd1);
        issue(16'h00F0, 5'd2, 1'b1);
        chk("b2b_hold_result", 32'(result), 32'hFE00);
        chk("b2b_hold_done", 32'(done), 32'd0);
        wait_done(0, lat, bok);
        chk("b2b_second_lat", 32'(lat), 32'd3);
        chk("b2b_second_result", 32'(result), 32'h003C);

        // Asynchronous reset in the middle of a shift.
        @(negedge clk);
        issue(16'hFFFF, 5'd8, 1'b1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(ready), 32'd1);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_result", 32'(result), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("mid_rst_no_done", 32'(seen), 32'd0);

        issue(16'h8000, 5'd2, 1'b0);
        wait_done(0, lat, bok);
        chk("post_rst_lat", 32'(lat), 32'd3);
        chk("post_rst_result", 32'(result), 32'hE000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
